dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4: maximum consecutive locked grants to one master while the other master is requesting.
REQ-002 Clock and reset are i_clk and i_rst: one clock; reset is synchronous and active-high.
REQ-003 i_clk  in  1  clock; all state updates on rising edge.
REQ-004 i_rst  in  1  synchronous active-high reset.
REQ-005 i_mN_req  in  1  (N=0,1) access request, held until granted.
REQ-006 i_mN_lock  in  1  request to keep ownership on the next cycle.
REQ-007 i_mN_we  in  1  write (1) / read (0).
REQ-008 i_mN_addr  in  XLEN  byte address.
REQ-009 i_mN_wdata  in  XLEN  write data.
REQ-010 i_mN_wstrb  in  XLEN/BYTE_WIDTH  byte write strobes.
REQ-011 o_mN_gnt  out  1  access accepted this cycle (combinational).
REQ-012 o_mN_rvalid  out  1  response valid, one cycle after grant.
REQ-013 o_mN_rdata  out  XLEN  read data, valid with rvalid.
REQ-014 o_mN_err  out  1  misaligned-access error, valid with rvalid.
REQ-015 o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb  out  1/XLEN/XLEN/XLEN/BYTE_WIDTH  drive data_mem.
REQ-016 i_mem_rdata  in  XLEN  data_mem combinational read data.

Function
REQ-017 At most one o_mN_gnt SHALL be high per cycle; a grant SHALL only be issued to a master whose i_mN_req is high.
REQ-018 With a single requester, that master SHALL be granted in the same cycle.
REQ-019 With both requesting and no active lock, the master not granted most recently SHALL win (round-robin); the last-grant pointer resets to 1, so m0 wins the first tie.
REQ-020 FSM states: ARB (no owner), OWN0, OWN1. ARB→OWNn when master n is granted with i_mn_lock=1. OWNn→ARB when master n is not requesting, drops lock, or is forced off per REQ-022.
REQ-021 In OWNn, master n SHALL be granted if requesting, regardless of the other master.
REQ-022 A burst counter SHALL count consecutive grants to the owner: set to 1 on entry to OWNn, increment per owner grant, saturate at MAX_BURST. When the count equals MAX_BURST and the other master requests, the other master SHALL win the next cycle.
REQ-023 A granted access is misaligned when addr[1:0]!=0. A misaligned access SHALL drive o_mem_we=0, SHALL be granted normally, and SHALL produce err=1 and rdata=0 at rvalid.
REQ-024 While master n is granted and aligned, o_mem_* SHALL equal master n's we/addr/wdata/wstrb; otherwise o_mem_we=0 and o_mem_addr/wdata/wstrb=0.
REQ-025 A write commits at the rising edge ending the grant cycle. rvalid SHALL pulse for exactly 1 cycle on the next cycle, with rdata=0.
REQ-026 For a read, i_mem_rdata SHALL be registered at the rising edge ending the grant cycle and presented with rvalid on the next cycle; rdata SHALL hold its value until the next response to that master.
REQ-027 Latency: grant in cycle t gives response in cycle t+1. Back-to-back grants SHALL give back-to-back responses with no bubble.
REQ-028 Inactive rvalid/err SHALL be 0.

Reset
REQ-029 While i_rst=1: state=ARB, burst counter=0, last-grant pointer=1, all o_mN_gnt/rvalid/err=0, o_mN_rdata=0, o_mem_we=0.
REQ-030 Reset asserted mid-burst or with a response pending SHALL drop the pending response; no rvalid SHALL appear in the cycle after reset deasserts.

Structure
REQ-031 XLEN and BYTE_WIDTH SHALL come from cotm32_pkg; the arb_state_t enum (ARB, OWN0, OWN1) SHALL be added to cotm32_pkg.
REQ-032 One sub-module, rr_pick2 (two-way round-robin picker with a pointer input), is natural; everything else SHALL stay in dmem_arbiter.

Verification (bench instantiates dmem_arbiter + data_mem, MEM_SIZE=16)
REQ-033 m0 writes 32'h11223344 to 0x0 with wstrb 1111; m0 then reads 0x0 -> gnt in the same cycle, rvalid next cycle, rdata=32'h11223344, err=0.
REQ-034 m0 reads 0x4 and m1 reads 0x8 in the same cycle after reset -> m0 granted first and m1 the next cycle; responses arrive in consecutive cycles.
REQ-035 m1 holds lock and req for 6 cycles while m0 requests continuously (MAX_BURST=4) -> m1 gets 4 grants, m0 the 5th, and m1 resumes afterwards.
REQ-036 m1 writes 32'haabbccdd with wstrb 0011 to 0x6 (misaligned) -> err=1, rdata=0; a later read of 0x4 returns the prior contents unchanged.
REQ-037 i_rst asserted in the cycle after a read grant -> no rvalid; all outputs are 0 during reset and in the cycle after reset.

Source files
------------

// File: rtl/cotm32_pkg.sv
// cotm32_pkg: shared widths, arbiter state encoding and address helpers.
package cotm32_pkg;
    localparam int XLEN = 32;
    localparam int BYTE_WIDTH = 8;
    localparam int STRB_W = XLEN / BYTE_WIDTH;

    typedef enum logic [1:0] {ARB, OWN0, OWN1} arb_state_t;

    function automatic logic misaligned(input logic [1:0] lo);
        return lo != 2'b00;
    endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: two master request/response channels plus the data_mem port.
interface dmem_arbiter_if;
    import cotm32_pkg::*;
    logic              i_m0_req, i_m0_lock, i_m0_we;
    logic [XLEN-1:0]   i_m0_addr, i_m0_wdata;
    logic [STRB_W-1:0] i_m0_wstrb;
    logic              o_m0_gnt, o_m0_rvalid, o_m0_err;
    logic [XLEN-1:0]   o_m0_rdata;
    logic              i_m1_req, i_m1_lock, i_m1_we;
    logic [XLEN-1:0]   i_m1_addr, i_m1_wdata;
    logic [STRB_W-1:0] i_m1_wstrb;
    logic              o_m1_gnt, o_m1_rvalid, o_m1_err;
    logic [XLEN-1:0]   o_m1_rdata;
    logic              o_mem_we;
    logic [XLEN-1:0]   o_mem_addr, o_mem_wdata, i_mem_rdata;
    logic [STRB_W-1:0] o_mem_wstrb;

    modport slave (
        input  i_m0_req, i_m0_lock, i_m0_we, i_m0_addr, i_m0_wdata, i_m0_wstrb,
        input  i_m1_req, i_m1_lock, i_m1_we, i_m1_addr, i_m1_wdata, i_m1_wstrb,
        input  i_mem_rdata,
        output o_m0_gnt, o_m0_rvalid, o_m0_err, o_m0_rdata,
        output o_m1_gnt, o_m1_rvalid, o_m1_err, o_m1_rdata,
        output o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb
    );
    modport master (
        output i_m0_req, i_m0_lock, i_m0_we, i_m0_addr, i_m0_wdata, i_m0_wstrb,
        output i_m1_req, i_m1_lock, i_m1_we, i_m1_addr, i_m1_wdata, i_m1_wstrb,
        output i_mem_rdata,
        input  o_m0_gnt, o_m0_rvalid, o_m0_err, o_m0_rdata,
        input  o_m1_gnt, o_m1_rvalid, o_m1_err, o_m1_rdata,
        input  o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb
    );
endinterface

// File: rtl/data_mem.sv
// data_mem: word-organised RAM with combinational read and byte-strobed write.
module data_mem import cotm32_pkg::*; #(
    parameter int MEM_SIZE = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic [XLEN-1:0]   rdata
);
    localparam int AW = $clog2(MEM_SIZE);
    logic [XLEN-1:0] mem [MEM_SIZE];
    logic [AW-1:0]   idx;
    logic            unused_addr;

    assign idx = addr[2 +: AW];
    assign rdata = mem[idx];
    assign unused_addr = ^{addr[XLEN-1:2+AW], addr[1:0]};

    always_ff @(posedge clk) begin
        if (we)
            for (int b = 0; b < STRB_W; b++)
                if (wstrb[b]) mem[idx][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
    end
endmodule

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin picker; ptr names the master granted last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);
    assign gnt = {req[1] & (~req[0] | ~ptr), req[0] & (~req[1] | ptr)};
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master data memory arbiter with round-robin, bounded lock
// bursts, misalignment errors and a one-cycle registered response.
module dmem_arbiter import cotm32_pkg::*; #(
    parameter int MAX_BURST = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    dmem_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BMAX = CW'(MAX_BURST);

    arb_state_t        state_q, state_d;
    logic [CW-1:0]     burst_q, burst_d;
    logic              last_q, last_d;
    logic [1:0]        rvalid_q, rvalid_d, err_q, err_d;
    logic [XLEN-1:0]   rdata_q [2];
    logic [XLEN-1:0]   rdata_d [2];
    logic [1:0]        req, lock, we, mis, pick, gnt;
    logic [XLEN-1:0]   addr [2];
    logic [XLEN-1:0]   wdata [2];
    logic [STRB_W-1:0] wstrb [2];
    logic              force_off, ptr, sel, hit, owner_keeps;

    assign req = {bus.i_m1_req, bus.i_m0_req};
    assign lock = {bus.i_m1_lock, bus.i_m0_lock};
    assign we = {bus.i_m1_we, bus.i_m0_we};
    assign addr = '{bus.i_m0_addr, bus.i_m1_addr};
    assign wdata = '{bus.i_m0_wdata, bus.i_m1_wdata};
    assign wstrb = '{bus.i_m0_wstrb, bus.i_m1_wstrb};
    assign mis = {misaligned(bus.i_m1_addr[1:0]), misaligned(bus.i_m0_addr[1:0])};

    // The owner is favoured by steering the picker pointer at the other master,
    // flipped once the owner has used its full burst and the other is waiting.
    assign force_off = state_q != ARB && burst_q == BMAX && (state_q == OWN0 ? req[1] : req[0]);
    assign ptr = state_q == ARB ? last_q : (state_q == OWN0) ^ force_off;

    rr_pick2 u_pick (.req(req), .ptr(ptr), .gnt(pick));

    assign gnt = i_rst ? 2'b00 : pick;
    assign sel = gnt[1];
    assign hit = |gnt & ~mis[sel];
    assign owner_keeps = state_q == ARB || state_q == (sel ? OWN1 : OWN0);

    assign bus.o_m0_gnt = gnt[0];
    assign bus.o_m1_gnt = gnt[1];
    assign bus.o_mem_we = hit & we[sel];
    assign bus.o_mem_addr = hit ? addr[sel] : '0;
    assign bus.o_mem_wdata = hit ? wdata[sel] : '0;
    assign bus.o_mem_wstrb = hit ? wstrb[sel] : '0;
    assign bus.o_m0_rvalid = rvalid_q[0] & ~i_rst;
    assign bus.o_m1_rvalid = rvalid_q[1] & ~i_rst;
    assign bus.o_m0_err = err_q[0] & ~i_rst;
    assign bus.o_m1_err = err_q[1] & ~i_rst;
    assign bus.o_m0_rdata = i_rst ? '0 : rdata_q[0];
    assign bus.o_m1_rdata = i_rst ? '0 : rdata_q[1];

    always_comb begin
        state_d = ARB;
        burst_d = '0;
        last_d = |gnt ? sel : last_q;
        rvalid_d = gnt;
        err_d = gnt & mis;
        rdata_d[0] = gnt[0] ? ((we[0] | mis[0]) ? '0 : bus.i_mem_rdata) : rdata_q[0];
        rdata_d[1] = gnt[1] ? ((we[1] | mis[1]) ? '0 : bus.i_mem_rdata) : rdata_q[1];
        if (|gnt && lock[sel] && owner_keeps) begin
            state_d = sel ? OWN1 : OWN0;
            burst_d = state_q == ARB ? CW'(1) : (burst_q == BMAX ? BMAX : burst_q + CW'(1));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ARB;
            burst_q <= '0;
            last_q <= 1'b1;
            rvalid_q <= '0;
            err_q <= '0;
            rdata_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            last_q <= last_d;
            rvalid_q <= rvalid_d;
            err_q <= err_d;
            rdata_q <= rdata_d;
        end
    end
endmodule
